// File: rtl/umac_cmd_seq.sv
// Command sequencer for the uMac block: queues operand sets, issues one at a time,
// waits out the uMac output register, and hands each result back with its tag.
module umac_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [15:0]   i_cmd_a1,
   input  logic [15:0]   i_cmd_a2,
   input  logic [15:0]   i_cmd_b1,
   input  logic [15:0]   i_cmd_b2,
   input  logic          i_cmd_mode,
   input  logic [1:0]    i_cmd_task,
   input  logic [3:0]    i_cmd_tag,
   output logic [15:0]   o_mac_a1,
   output logic [15:0]   o_mac_a2,
   output logic [15:0]   o_mac_b1,
   output logic [15:0]   o_mac_b2,
   output logic          o_mac_mode,
   output logic [1:0]    o_mac_task,
   input  logic [31:0]   i_mac_out1,
   input  logic [31:0]   i_mac_out2,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [31:0]   o_res_out1,
   output logic [31:0]   o_res_out2,
   output logic [3:0]    o_res_tag,
   output logic [AW:0]   o_count,
   output logic          o_busy
);

   // Entry layout: {a1, a2, b1, b2, mode, task, tag}
   localparam int        EW       = 71;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            push, pop;

   logic [15:0]     mac_a1_q, mac_a1_d;
   logic [15:0]     mac_a2_q, mac_a2_d;
   logic [15:0]     mac_b1_q, mac_b1_d;
   logic [15:0]     mac_b2_q, mac_b2_d;
   logic            mac_mode_q, mac_mode_d;
   logic [1:0]      mac_task_q, mac_task_d;
   logic [3:0]      issue_tag_q, issue_tag_d;

   logic            res_valid_q, res_valid_d;
   logic [31:0]     res_out1_q, res_out1_d;
   logic [31:0]     res_out2_q, res_out2_d;
   logic [3:0]      res_tag_q, res_tag_d;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mac_a1_d    = mac_a1_q;
      mac_a2_d    = mac_a2_q;
      mac_b1_d    = mac_b1_q;
      mac_b2_d    = mac_b2_q;
      mac_mode_d  = mac_mode_q;
      mac_task_d  = mac_task_q;
      issue_tag_d = issue_tag_q;
      res_valid_d = res_valid_q;
      res_out1_d  = res_out1_q;
      res_out2_d  = res_out2_q;
      res_tag_d   = res_tag_q;
      // A full FIFO refuses the push even when a pop frees a slot this cycle
      push        = i_cmd_valid && (count_q != FULL_CNT);
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            res_out1_d  = i_mac_out1;
            res_out2_d  = i_mac_out2;
            res_tag_d   = issue_tag_q;
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (i_res_ready) begin
               res_valid_d = 1'b0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         {mac_a1_d, mac_a2_d, mac_b1_d, mac_b2_d,
          mac_mode_d, mac_task_d, issue_tag_d} = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; only occupancy and pointers define what is valid
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {i_cmd_a1, i_cmd_a2, i_cmd_b1, i_cmd_b2,
                             i_cmd_mode, i_cmd_task, i_cmd_tag};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mac_a1_q    <= '0;
         mac_a2_q    <= '0;
         mac_b1_q    <= '0;
         mac_b2_q    <= '0;
         mac_mode_q  <= 1'b0;
         mac_task_q  <= '0;
         issue_tag_q <= '0;
         res_valid_q <= 1'b0;
         res_out1_q  <= '0;
         res_out2_q  <= '0;
         res_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mac_a1_q    <= mac_a1_d;
         mac_a2_q    <= mac_a2_d;
         mac_b1_q    <= mac_b1_d;
         mac_b2_q    <= mac_b2_d;
         mac_mode_q  <= mac_mode_d;
         mac_task_q  <= mac_task_d;
         issue_tag_q <= issue_tag_d;
         res_valid_q <= res_valid_d;
         res_out1_q  <= res_out1_d;
         res_out2_q  <= res_out2_d;
         res_tag_q   <= res_tag_d;
      end
   end

   assign o_cmd_ready = (count_q != FULL_CNT);
   assign o_count     = count_q;
   assign o_busy      = (state_q != IDLE) || (count_q != '0);
   assign o_mac_a1    = mac_a1_q;
   assign o_mac_a2    = mac_a2_q;
   assign o_mac_b1    = mac_b1_q;
   assign o_mac_b2    = mac_b2_q;
   assign o_mac_mode  = mac_mode_q;
   assign o_mac_task  = mac_task_q;
   assign o_res_valid = res_valid_q;
   assign o_res_out1  = res_out1_q;
   assign o_res_out2  = res_out2_q;
   assign o_res_tag   = res_tag_q;

endmodule

// File: tb/tb_umac_cmd_seq.sv
// Testbench for umac_cmd_seq: a per-cycle vector table for the single and
// back-to-back cases, then hand-written full-FIFO, stall, wrap and reset sequences.
module tb_umac_cmd_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [15:0] i_cmd_a1, i_cmd_a2, i_cmd_b1, i_cmd_b2;
   logic        i_cmd_mode;
   logic [1:0]  i_cmd_task;
   logic [3:0]  i_cmd_tag;
   logic [15:0] o_mac_a1, o_mac_a2, o_mac_b1, o_mac_b2;
   logic        o_mac_mode;
   logic [1:0]  o_mac_task;
   logic [31:0] i_mac_out1, i_mac_out2;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [31:0] o_res_out1, o_res_out2;
   logic [3:0]  o_res_tag;
   logic [2:0]  o_count;
   logic        o_busy;

   int num_checks = 0;
   int num_errors = 0;

   logic [3:0]  exp_q[$];

   typedef struct {
      logic        valid;
      logic [15:0] a1, a2, b1, b2;
      logic        mode;
      logic [1:0]  tsk;
      logic [3:0]  tag;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_out1, exp_out2;
      logic [3:0]  exp_tag;
      logic [2:0]  exp_count;
      logic        exp_crdy;
      logic        exp_busy;
      logic        chk_mac;
      logic        exp_mode;
      logic [1:0]  exp_task;
   } vec_t;

   vec_t vecs[$];
   vec_t v;

   umac_cmd_seq dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_a1    (i_cmd_a1),
      .i_cmd_a2    (i_cmd_a2),
      .i_cmd_b1    (i_cmd_b1),
      .i_cmd_b2    (i_cmd_b2),
      .i_cmd_mode  (i_cmd_mode),
      .i_cmd_task  (i_cmd_task),
      .i_cmd_tag   (i_cmd_tag),
      .o_mac_a1    (o_mac_a1),
      .o_mac_a2    (o_mac_a2),
      .o_mac_b1    (o_mac_b1),
      .o_mac_b2    (o_mac_b2),
      .o_mac_mode  (o_mac_mode),
      .o_mac_task  (o_mac_task),
      .i_mac_out1  (i_mac_out1),
      .i_mac_out2  (i_mac_out2),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_out1  (o_res_out1),
      .o_res_out2  (o_res_out2),
      .o_res_tag   (o_res_tag),
      .o_count     (o_count),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // uMac stand-in: one register stage, out1 = {a2,a1}, out2 = {b2,b1}
   always @(posedge i_clk) begin
      i_mac_out1 <= {o_mac_a2, o_mac_a1};
      i_mac_out2 <= {o_mac_b2, o_mac_b1};
   end

   function automatic logic [15:0] opA1(input logic [3:0] t); return {12'h100, t}; endfunction
   function automatic logic [15:0] opA2(input logic [3:0] t); return {12'h200, t}; endfunction
   function automatic logic [15:0] opB1(input logic [3:0] t); return {12'h300, t}; endfunction
   function automatic logic [15:0] opB2(input logic [3:0] t); return {12'h400, t}; endfunction
   function automatic logic [31:0] expOut1(input logic [3:0] t); return {opA2(t), opA1(t)}; endfunction
   function automatic logic [31:0] expOut2(input logic [3:0] t); return {opB2(t), opB1(t)}; endfunction

   function automatic vec_t row(input logic vl, input logic [3:0] t, input logic rdy,
                                input logic ev, input logic [3:0] et, input int cnt,
                                input logic bz);
      vec_t r;
      r.valid     = vl;
      r.a1        = opA1(t);
      r.a2        = opA2(t);
      r.b1        = opB1(t);
      r.b2        = opB2(t);
      r.mode      = t[0];
      r.tsk       = t[2:1];
      r.tag       = t;
      r.ready     = rdy;
      r.exp_valid = ev;
      r.exp_tag   = et;
      r.exp_out1  = expOut1(et);
      r.exp_out2  = expOut2(et);
      r.exp_count = 3'(cnt);
      r.exp_crdy  = (cnt != 4);
      r.exp_busy  = bz;
      r.chk_mac   = 1'b0;
      r.exp_mode  = 1'b0;
      r.exp_task  = 2'd0;
      return r;
   endfunction

   function automatic vec_t withMac(input vec_t r, input logic m, input logic [1:0] tk);
      vec_t o;
      o          = r;
      o.chk_mac  = 1'b1;
      o.exp_mode = m;
      o.exp_task = tk;
      return o;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t s);
      i_cmd_valid = s.valid;
      i_cmd_a1    = s.a1;
      i_cmd_a2    = s.a2;
      i_cmd_b1    = s.b1;
      i_cmd_b2    = s.b2;
      i_cmd_mode  = s.mode;
      i_cmd_task  = s.tsk;
      i_cmd_tag   = s.tag;
      i_res_ready = s.ready;
      @(posedge i_clk);
      #1;
   endtask

   task automatic pushCmd(input logic [3:0] t);
      i_cmd_valid = 1'b1;
      i_cmd_a1    = opA1(t);
      i_cmd_a2    = opA2(t);
      i_cmd_b1    = opB1(t);
      i_cmd_b2    = opB2(t);
      i_cmd_mode  = t[0];
      i_cmd_task  = t[2:1];
      i_cmd_tag   = t;
      @(posedge i_clk);
      #1;
      i_cmd_valid = 1'b0;
   endtask

   // Records each handshake (valid & ready before an edge) against exp_q in order
   task automatic collectResults(input logic toggle, input int budget);
      int   idx;
      int   cyc;
      logic rdy;
      idx = 0;
      cyc = 0;
      rdy = 1'b0;
      i_cmd_valid = 1'b0;
      while (cyc < budget && !(idx >= exp_q.size() && !o_busy)) begin
         i_res_ready = toggle ? rdy : 1'b1;
         if (o_res_valid && i_res_ready) begin
            if (idx < exp_q.size()) begin
               checkOutput($sformatf("rx%0d_tag", idx), 32'(o_res_tag), 32'(exp_q[idx]));
               checkOutput($sformatf("rx%0d_out1", idx), o_res_out1, expOut1(exp_q[idx]));
               checkOutput($sformatf("rx%0d_out2", idx), o_res_out2, expOut2(exp_q[idx]));
            end else begin
               num_checks++;
               num_errors++;
               $display("[TB] FAIL extra_result: got tag 0x%0h, expected no further result", o_res_tag);
            end
            idx++;
         end
         @(posedge i_clk);
         #1;
         cyc++;
         rdy = ~rdy;
      end
      checkOutput("result_count", 32'(idx), 32'(exp_q.size()));
      i_res_ready = 1'b1;
   endtask

   task automatic checkResetState(input string pfx);
      checkOutput({pfx, "_res_valid"}, 32'(o_res_valid), 32'd0);
      checkOutput({pfx, "_res_out1"},  o_res_out1, 32'd0);
      checkOutput({pfx, "_res_out2"},  o_res_out2, 32'd0);
      checkOutput({pfx, "_res_tag"},   32'(o_res_tag), 32'd0);
      checkOutput({pfx, "_count"},     32'(o_count), 32'd0);
      checkOutput({pfx, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
      checkOutput({pfx, "_busy"},      32'(o_busy), 32'd0);
      checkOutput({pfx, "_mac_a1"},    32'(o_mac_a1), 32'd0);
      checkOutput({pfx, "_mac_b2"},    32'(o_mac_b2), 32'd0);
      checkOutput({pfx, "_mac_mode"},  32'(o_mac_mode), 32'd0);
      checkOutput({pfx, "_mac_task"},  32'(o_mac_task), 32'd0);
   endtask

   initial begin
      logic seen;
      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_a1    = '0;
      i_cmd_a2    = '0;
      i_cmd_b1    = '0;
      i_cmd_b2    = '0;
      i_cmd_mode  = 1'b0;
      i_cmd_task  = '0;
      i_cmd_tag   = '0;
      i_res_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      checkResetState("reset");

      // Single command: push at N, issue at N+1, result valid after N+3
      v = row(1, 5, 0, 0, 0, 1, 1);
      v.a1 = 16'h0001; v.a2 = 16'h0002; v.b1 = 16'h0003; v.b2 = 16'h0004;
      v.mode = 1'b1; v.tsk = 2'd2;
      vecs.push_back(withMac(v, 1'b0, 2'd0));
      vecs.push_back(withMac(row(0, 0, 0, 0, 0, 0, 1), 1'b1, 2'd2));
      vecs.push_back(withMac(row(0, 0, 0, 0, 0, 0, 1), 1'b1, 2'd2));
      v = row(0, 0, 0, 1, 5, 0, 1);
      v.exp_out1 = 32'h0002_0001; v.exp_out2 = 32'h0004_0003;
      vecs.push_back(v);
      vecs.push_back(row(0, 0, 1, 0, 0, 0, 0));

      // Back-to-back tags 1..4 with the consumer always ready
      vecs.push_back(row(1, 1, 1, 0, 0, 1, 1));
      vecs.push_back(withMac(row(1, 2, 1, 0, 0, 1, 1), 1'b1, 2'd0));
      vecs.push_back(row(1, 3, 1, 0, 0, 2, 1));
      vecs.push_back(row(1, 4, 1, 1, 1, 3, 1));
      vecs.push_back(withMac(row(0, 0, 1, 0, 0, 2, 1), 1'b0, 2'd1));
      vecs.push_back(row(0, 0, 1, 0, 0, 2, 1));
      vecs.push_back(row(0, 0, 1, 1, 2, 2, 1));
      vecs.push_back(row(0, 0, 1, 0, 0, 1, 1));
      vecs.push_back(row(0, 0, 1, 0, 0, 1, 1));
      vecs.push_back(row(0, 0, 1, 1, 3, 1, 1));
      vecs.push_back(withMac(row(0, 0, 1, 0, 0, 0, 1), 1'b0, 2'd2));
      vecs.push_back(row(0, 0, 1, 0, 0, 0, 1));
      vecs.push_back(row(0, 0, 1, 1, 4, 0, 1));
      vecs.push_back(row(0, 0, 1, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_res_valid", i), 32'(o_res_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("v%0d_res_tag", i), 32'(o_res_tag), 32'(vecs[i].exp_tag));
            checkOutput($sformatf("v%0d_res_out1", i), o_res_out1, vecs[i].exp_out1);
            checkOutput($sformatf("v%0d_res_out2", i), o_res_out2, vecs[i].exp_out2);
         end
         checkOutput($sformatf("v%0d_count", i), 32'(o_count), 32'(vecs[i].exp_count));
         checkOutput($sformatf("v%0d_cmd_ready", i), 32'(o_cmd_ready), 32'(vecs[i].exp_crdy));
         checkOutput($sformatf("v%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
         if (vecs[i].chk_mac) begin
            checkOutput($sformatf("v%0d_mac_mode", i), 32'(o_mac_mode), 32'(vecs[i].exp_mode));
            checkOutput($sformatf("v%0d_mac_task", i), 32'(o_mac_task), 32'(vecs[i].exp_task));
         end
      end
      i_cmd_valid = 1'b0;

      // Full FIFO with the consumer stalled: tag 10 in HOLD, 11..14 queued, 15 refused
      $display("[TB] full FIFO");
      i_res_ready = 1'b0;
      for (int t = 10; t <= 14; t++) pushCmd(4'(t));
      checkOutput("full_count", 32'(o_count), 32'd4);
      checkOutput("full_cmd_ready", 32'(o_cmd_ready), 32'd0);
      pushCmd(4'd15);
      checkOutput("refused_count", 32'(o_count), 32'd4);
      checkOutput("refused_cmd_ready", 32'(o_cmd_ready), 32'd0);
      for (int c = 0; c < 10; c++) begin
         checkOutput($sformatf("stall%0d_valid", c), 32'(o_res_valid), 32'd1);
         checkOutput($sformatf("stall%0d_tag", c), 32'(o_res_tag), 32'd10);
         checkOutput($sformatf("stall%0d_out1", c), o_res_out1, expOut1(4'd10));
         checkOutput($sformatf("stall%0d_out2", c), o_res_out2, expOut2(4'd10));
         @(posedge i_clk);
         #1;
      end
      exp_q.delete();
      for (int t = 10; t <= 14; t++) exp_q.push_back(4'(t));
      collectResults(1'b0, 60);
      checkOutput("full_drained_count", 32'(o_count), 32'd0);

      // Consumer toggling ready every cycle
      $display("[TB] toggling ready");
      i_res_ready = 1'b0;
      exp_q.delete();
      for (int k = 1; k <= 4; k++) begin
         pushCmd(4'(3 * k));
         exp_q.push_back(4'(3 * k));
      end
      collectResults(1'b1, 80);

      // Wrap-around: ten commands one at a time through a four-entry FIFO
      $display("[TB] wrap-around");
      for (int t = 0; t < 10; t++) begin
         pushCmd(4'(t));
         exp_q.delete();
         exp_q.push_back(4'(t));
         collectResults(1'b0, 20);
      end
      checkOutput("wrap_count", 32'(o_count), 32'd0);
      checkOutput("wrap_busy", 32'(o_busy), 32'd0);

      // Asynchronous reset during CAPTURE with two commands queued
      $display("[TB] reset mid-operation");
      i_res_ready = 1'b0;
      pushCmd(4'd1);
      pushCmd(4'd2);
      pushCmd(4'd3);
      checkOutput("prereset_count", 32'(o_count), 32'd2);
      #2;
      i_rst = 1'b1;
      #1;
      checkResetState("async_reset");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      i_res_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (o_res_valid || o_busy) seen = 1'b1;
         @(posedge i_clk);
         #1;
      end
      checkOutput("no_stale_result", 32'(seen), 32'd0);
      pushCmd(4'd7);
      exp_q.delete();
      exp_q.push_back(4'd7);
      collectResults(1'b0, 20);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
